// File: rtl/instr_loader.sv
// Boot loader: receives a header, N instruction words and a checksum from the host,
// writes the words into instruction memory and releases the processor once verified.
module instr_loader #(
  parameter int           ADDR_W = 8,
  parameter int           DATA_W = 16,
  parameter logic [7:0]   SYNC   = 8'hA5
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic              Reload,
  output logic              IM_Wr,
  output logic [ADDR_W-1:0] IM_Addr,
  output logic [DATA_W-1:0] IM_Data,
  output logic              Proc_Reset,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   Word_Count,
  output logic [2:0]        State
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W:0]   n_q,        n_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] sum_q,      sum_d;
  logic [ADDR_W:0]   cnt_q,      cnt_d;
  logic              im_wr_q,    im_wr_d;
  logic [ADDR_W-1:0] im_addr_q,  im_addr_d;
  logic [DATA_W-1:0] im_data_q,  im_data_d;
  logic              proc_rst_q, proc_rst_d;
  logic              done_q,     done_d;
  logic              err_q,      err_d;
  logic              ready_s;
  logic              xfer_s;

  // Ready only in the receiving states, and never while a reset or reload is pending
  always_comb begin
    ready_s = 1'b0;
    if (!Reset && !Reload &&
        ((state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CHECK))) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    xfer_s = In_Valid && ready_s;
  end

  // Next-state and datapath logic
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    addr_d    = addr_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    im_wr_d   = 1'b0;
    im_addr_d = im_addr_q;
    im_data_d = im_data_q;
    if (Reload) begin
      state_d = ST_IDLE;
      addr_d  = '0;
      sum_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (xfer_s) begin
            if (In_Data[DATA_W-1 -: 8] == SYNC) begin
              // header carries N-1, so N spans 1..2^ADDR_W in the wider count
              n_d     = {1'b0, In_Data[ADDR_W-1:0]} + CNT_ONE;
              addr_d  = '0;
              sum_d   = '0;
              cnt_d   = '0;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_ERR;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (xfer_s) begin
            im_wr_d   = 1'b1;
            im_addr_d = addr_q;
            im_data_d = In_Data;
            sum_d     = sum_q + In_Data;
            addr_d    = addr_q + ADDR_ONE;
            cnt_d     = cnt_q + CNT_ONE;
            if ((cnt_q + CNT_ONE) == n_q) begin
              state_d = ST_CHECK;
            end else begin
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_CHECK: begin
          if (xfer_s) begin
            if (In_Data == sum_q) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_ERR;
            end
          end else begin
            state_d = ST_CHECK;
          end
        end
        ST_RUN:  state_d = ST_RUN;
        ST_ERR:  state_d = ST_ERR;
        default: state_d = ST_IDLE;
      endcase
    end
    proc_rst_d = (state_d != ST_RUN);
    done_d     = (state_d == ST_RUN);
    err_d      = (state_d == ST_ERR);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      n_q        <= '0;
      addr_q     <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      im_wr_q    <= 1'b0;
      im_addr_q  <= '0;
      im_data_q  <= '0;
      proc_rst_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      im_wr_q    <= im_wr_d;
      im_addr_q  <= im_addr_d;
      im_data_q  <= im_data_d;
      proc_rst_q <= proc_rst_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign In_Ready   = ready_s;
  assign IM_Wr      = im_wr_q;
  assign IM_Addr    = im_addr_q;
  assign IM_Data    = im_data_q;
  assign Proc_Reset = proc_rst_q;
  assign Done       = done_q;
  assign Error      = err_q;
  assign Word_Count = cnt_q;
  assign State      = state_q;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: expected memory writes are queued by the stimulus
// and checked by an independent monitor; status outputs are checked at key points.
module tb_instr_loader;

  logic        clk;
  logic        Reset;
  logic [15:0] In_Data;
  logic        In_Valid;
  logic        In_Ready;
  logic        Reload;
  logic        IM_Wr;
  logic [7:0]  IM_Addr;
  logic [15:0] IM_Data;
  logic        Proc_Reset;
  logic        Done;
  logic        Error;
  logic [8:0]  Word_Count;
  logic [2:0]  State;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int w0;
  logic [23:0] sb_q[$];
  logic [7:0]  exp_addr;
  logic [15:0] exp_sum;

  instr_loader dut (
    .clk(clk), .Reset(Reset), .In_Data(In_Data), .In_Valid(In_Valid),
    .In_Ready(In_Ready), .Reload(Reload), .IM_Wr(IM_Wr), .IM_Addr(IM_Addr),
    .IM_Data(IM_Data), .Proc_Reset(Proc_Reset), .Done(Done), .Error(Error),
    .Word_Count(Word_Count), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (IM_Wr === 1'b1) begin
      wr_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h, none expected", IM_Addr, IM_Data);
      end else begin
        logic [23:0] e;
        e = sb_q.pop_front();
        if ({IM_Addr, IM_Data} !== e) begin
          errors++;
          $display("FAIL im_write: got addr %0h data %0h expected addr %0h data %0h",
                   IM_Addr, IM_Data, e[23:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [15:0] d, input int gap);
    In_Valid = 1'b1;
    In_Data  = d;
    @(negedge clk);
    In_Valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic header(input logic [15:0] h);
    exp_addr = 8'd0;
    exp_sum  = 16'd0;
    send(h, 0);
  endtask

  task automatic ldw(input logic [15:0] d, input int gap);
    sb_q.push_back({exp_addr, d});
    exp_addr = exp_addr + 8'd1;
    exp_sum  = exp_sum + d;
    send(d, gap);
  endtask

  task automatic reload_pulse();
    Reload = 1'b1;
    #1 chk("ready_low_during_reload", 32'(In_Ready), 32'd0);
    @(negedge clk);
    Reload = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Reload = 1'b0; In_Valid = 1'b0; In_Data = 16'h0000;
    exp_addr = 8'd0; exp_sum = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_ready", 32'(In_Ready), 32'd0);
    chk("rst_proc_reset", 32'(Proc_Reset), 32'd1);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_error", 32'(Error), 32'd0);
    chk("rst_word_count", 32'(Word_Count), 32'd0);
    chk("rst_im_wr", 32'(IM_Wr), 32'd0);
    Reset = 1'b0;
    #1 chk("ready_after_reset", 32'(In_Ready), 32'd1);

    // Basic 3-word load with good checksum
    header(16'hA502);
    chk("load_state", 32'(State), 32'd1);
    ldw(16'h1234, 0); ldw(16'h0001, 0); ldw(16'hFFFF, 0);
    chk("check_state", 32'(State), 32'd2);
    chk("wc_3", 32'(Word_Count), 32'd3);
    chk("proc_reset_in_check", 32'(Proc_Reset), 32'd1);
    send(16'h1234, 0);
    chk("run_state", 32'(State), 32'd3);
    chk("run_proc_reset", 32'(Proc_Reset), 32'd0);
    chk("run_done", 32'(Done), 32'd1);
    chk("run_error", 32'(Error), 32'd0);
    chk("run_ready", 32'(In_Ready), 32'd0);
    chk("run_wc", 32'(Word_Count), 32'd3);
    w0 = wr_count;
    send(16'hBEEF, 2);
    chk("run_holds", 32'(State), 32'd3);
    chk("run_no_write", 32'(wr_count - w0), 32'd0);
    reload_pulse();
    chk("reload_state", 32'(State), 32'd0);
    chk("reload_done", 32'(Done), 32'd0);
    chk("reload_proc_reset", 32'(Proc_Reset), 32'd1);
    chk("reload_wc", 32'(Word_Count), 32'd0);

    // Bad checksum
    header(16'hA502);
    ldw(16'h1234, 0); ldw(16'h0001, 0); ldw(16'hFFFF, 0);
    send(16'h1235, 0);
    chk("bad_sum_state", 32'(State), 32'd4);
    chk("bad_sum_error", 32'(Error), 32'd1);
    chk("bad_sum_proc_reset", 32'(Proc_Reset), 32'd1);
    chk("bad_sum_done", 32'(Done), 32'd0);
    chk("err_ready", 32'(In_Ready), 32'd0);
    reload_pulse();
    chk("err_reload_state", 32'(State), 32'd0);
    chk("err_reload_error", 32'(Error), 32'd0);

    // Bad sync
    w0 = wr_count;
    header(16'h5A00);
    chk("bad_sync_state", 32'(State), 32'd4);
    chk("bad_sync_error", 32'(Error), 32'd1);
    send(16'h0000, 2);
    chk("bad_sync_no_write", 32'(wr_count - w0), 32'd0);
    reload_pulse();

    // Aborted load then fresh load: sum must exclude aborted words
    header(16'hA502);
    ldw(16'h1111, 0); ldw(16'h2222, 0);
    reload_pulse();
    chk("abort_state", 32'(State), 32'd0);
    chk("abort_wc", 32'(Word_Count), 32'd0);
    header(16'hA502);
    ldw(16'h0A0A, 0); ldw(16'h0B0B, 0); ldw(16'h0C0C, 0);
    send(16'h2121, 0);
    chk("abort_reload_run", 32'(State), 32'd3);
    reload_pulse();

    // Full 256-word load with In_Valid toggling
    header(16'hA5FF);
    w0 = wr_count;
    for (int i = 0; i < 256; i++) ldw(16'(i * 37 + 5), 1);
    chk("n256_check_state", 32'(State), 32'd2);
    chk("n256_wc", 32'(Word_Count), 32'd256);
    chk("n256_writes", 32'(wr_count - w0), 32'd256);
    send(exp_sum, 0);
    chk("n256_run", 32'(State), 32'd3);
    reload_pulse();

    // Asynchronous reset between edges in the middle of a load
    header(16'hA502);
    ldw(16'h4444, 0); ldw(16'h5555, 0);
    #2 Reset = 1'b1;
    #1;
    chk("arst_state", 32'(State), 32'd0);
    chk("arst_im_wr", 32'(IM_Wr), 32'd0);
    chk("arst_im_addr", 32'(IM_Addr), 32'd0);
    chk("arst_im_data", 32'(IM_Data), 32'd0);
    chk("arst_proc_reset", 32'(Proc_Reset), 32'd1);
    chk("arst_wc", 32'(Word_Count), 32'd0);
    chk("arst_ready", 32'(In_Ready), 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    header(16'hA501);
    ldw(16'h00FF, 0); ldw(16'hFF01, 0);
    send(16'h0000, 0);
    chk("arst_reload_run", 32'(State), 32'd3);
    chk("arst_reload_done", 32'(Done), 32'd1);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001: The module SHALL have parameter ADDR_W, default 8, meaning instruction-memory address width (the same width as the program counter).
REQ-002: The module SHALL have parameter DATA_W, default 16, meaning instruction word width.
REQ-003: The module SHALL have parameter SYNC, default 8'hA5, meaning the header sync byte.
REQ-004: clk  input  1  single system clock; all state changes on rising edge.
REQ-005: Reset  input  1  asynchronous, active-high reset.
REQ-006: In_Data  input  16  word from host: header, instruction, or checksum.
REQ-007: In_Valid  input  1  In_Data valid this cycle.
REQ-008: In_Ready  output  1  loader accepts In_Data this cycle; a transfer occurs on the edge where In_Valid and In_Ready are both 1.
REQ-009: Reload  input  1  synchronous request to abort or restart loading.
REQ-010: IM_Wr  output  1  instruction-memory write strobe.
REQ-011: IM_Addr  output  8  instruction-memory write address.
REQ-012: IM_Data  output  16  instruction-memory write data.
REQ-013: Proc_Reset  output  1  drives the processor Reset; 1 holds the processor in reset.
REQ-014: Done  output  1  program loaded and verified; processor released.
REQ-015: Error  output  1  load failed (bad sync or checksum).
REQ-016: Word_Count  output  9  number of instruction words written in the current load.
REQ-017: State  output  3  FSM state: IDLE=0, LOAD=1, CHECK=2, RUN=3, ERR=4.

Function
REQ-018: Protocol: one header word, then N instruction words, then one checksum word; header [15:8]=SYNC; header [7:0]=N-1, so N ranges 1..256.
REQ-019: IDLE: In_Ready=1.
  - Accepted header with correct sync: latch N, clear address and sum, go to LOAD.
  - Accepted header with wrong sync: go to ERR.
REQ-020: LOAD: In_Ready=1.
  - Each accepted word writes the instruction memory, adds to the 16-bit sum (mod 2^16), increments address and Word_Count.
  - Transfer of word N: go to CHECK.
REQ-021: Write timing: IM_Wr is registered; it pulses 1 for exactly one cycle, the cycle after each LOAD acceptance.
  - IM_Addr = 0,1,2,... for consecutive words.
  - IM_Data = the accepted word.
  - Cycles with In_Valid=0 produce no write and no address change.
REQ-022: CHECK: In_Ready=1.
  - Accepted word equal to the sum: go to RUN.
  - Otherwise: go to ERR.
REQ-023: RUN: In_Ready=0, Proc_Reset=0, Done=1; the loader holds this state until Reload.
REQ-024: ERR: In_Ready=0, Proc_Reset=1, Error=1; the loader holds this state until Reload.
REQ-025: Proc_Reset SHALL be 1 in every state except RUN; it deasserts on the first clock in RUN, and all IM writes are complete before then.
REQ-026: Reload=1 in any state: go to IDLE next edge; clear address, sum, Word_Count, Done and Error; set Proc_Reset=1. Any word presented that cycle is ignored (In_Ready=0 while Reload=1).
REQ-027: Address arithmetic is ADDR_W bits. N=256 writes addresses 0..255 with no wrap into a 257th write, and Word_Count reaches 256.
REQ-028: The checksum covers only the N instruction words, never the header.

Reset
REQ-029: Reset=1, asynchronously and including mid-LOAD, SHALL force:
  - State=IDLE, In_Ready=0 while Reset is held
  - IM_Wr=0, IM_Addr=0, IM_Data=0
  - Proc_Reset=1, Done=0, Error=0, Word_Count=0
  - internal sum and count cleared
REQ-030: After Reset falls, the first transfer can occur on the first rising edge.

Verification
REQ-031: Header 16'hA502, words 16'h1234, 16'h0001, 16'hFFFF, checksum 16'h1234 -> writes (0,1234),(1,0001),(2,FFFF); Word_Count=3; State=RUN; Proc_Reset=0; Done=1.
REQ-032: Same load with checksum 16'h1235 -> State=ERR, Error=1, Proc_Reset=1; then Reload pulse -> State=IDLE, Error=0.
REQ-033: Header 16'h5A00 -> State=ERR immediately; zero IM_Wr pulses.
REQ-034: Header 16'hA5FF, 256 words with In_Valid toggling every other cycle -> exactly 256 IM_Wr pulses at addresses 0..255; Word_Count=256; CHECK reached after word 256.
REQ-035: Reload asserted after 2 of 3 words, then a fresh full load -> addresses restart at 0, the sum excludes the aborted words, and the correct checksum reaches RUN.
REQ-036: Reset asserted mid-LOAD between clock edges -> outputs take reset values immediately, without waiting for an edge; a following full load succeeds.
